user_gpio_ctrl: RTL and testbench

USER_GPIO_CTRL -- requirements
Module: user_gpio_ctrl

---
 rtl/user_gpio_ctrl.sv | 140 ++++++++++++++
 tb/tb_user_gpio_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/user_gpio_ctrl.sv
// Memory-mapped GPIO block: output/enable registers, synchronized inputs and
// per-line rise/fall edge interrupts. Each bus request completes with a one-cycle ready pulse.
module user_gpio_ctrl #(
  parameter int GPIO_NUM = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                mem_valid_i,
  input  logic [7:0]          mem_addr_i,
  input  logic [31:0]         mem_wdata_i,
  input  logic [3:0]          mem_wstrb_i,
  output logic                mem_ready_o,
  output logic [31:0]         mem_rdata_o,
  output logic [GPIO_NUM-1:0] gpio_out_o,
  output logic [GPIO_NUM-1:0] gpio_oe_o,
  input  logic [GPIO_NUM-1:0] gpio_in_i,
  output logic                irq_o
);

  typedef enum logic [2:0] {
    REG_OE      = 3'd0,
    REG_DO      = 3'd1,
    REG_DI      = 3'd2,
    REG_RISE_EN = 3'd3,
    REG_FALL_EN = 3'd4,
    REG_PEND    = 3'd5,
    REG_DO_SET  = 3'd6,
    REG_DO_CLR  = 3'd7
  } reg_e;

  logic [GPIO_NUM-1:0] oe_q, do_q, rise_en_q, fall_en_q, pend_q;
  logic [GPIO_NUM-1:0] s1_q, s2_q, s3_q;
  logic [GPIO_NUM-1:0] oe_d, do_d, rise_en_d, fall_en_d, pend_d;
  logic [GPIO_NUM-1:0] pend_set, pend_clr, wmask, wdata, wbits;
  logic                ready_q, irq_q;
  logic [31:0]         rdata_q, rdata_d, wmask32;
  logic                accept, wr_en;
  reg_e                reg_sel;
  logic                unused_bits;

  function automatic logic [31:0] zext(input logic [GPIO_NUM-1:0] v);
    logic [31:0] r;
    r = '0;
    r[GPIO_NUM-1:0] = v;
    return r;
  endfunction

  function automatic logic [GPIO_NUM-1:0] merge(input logic [GPIO_NUM-1:0] old_v,
                                                input logic [GPIO_NUM-1:0] new_v,
                                                input logic [GPIO_NUM-1:0] mask);
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  // A request held through the ready cycle is only re-accepted the cycle after.
  assign accept  = mem_valid_i & ~ready_q;
  assign wr_en   = accept & (|mem_wstrb_i);
  assign reg_sel = reg_e'(mem_addr_i[4:2]);
  assign wmask32 = {{8{mem_wstrb_i[3]}}, {8{mem_wstrb_i[2]}},
                    {8{mem_wstrb_i[1]}}, {8{mem_wstrb_i[0]}}};
  assign wmask   = wmask32[GPIO_NUM-1:0];
  assign wdata   = mem_wdata_i[GPIO_NUM-1:0];
  assign wbits   = wdata & wmask;

  // Address bits outside [4:2] and data lanes above GPIO_NUM carry no meaning.
  assign unused_bits = ^{mem_addr_i[7:5], mem_addr_i[1:0], mem_wdata_i, wmask32};

  assign pend_set = (s2_q & ~s3_q & rise_en_q) | (~s2_q & s3_q & fall_en_q);

  always_comb begin
    oe_d      = oe_q;
    do_d      = do_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    pend_clr  = '0;
    rdata_d   = '0;

    if (accept) begin
      case (reg_sel)
        REG_OE:      rdata_d = zext(oe_q);
        REG_DO:      rdata_d = zext(do_q);
        REG_DI:      rdata_d = zext(s2_q);
        REG_RISE_EN: rdata_d = zext(rise_en_q);
        REG_FALL_EN: rdata_d = zext(fall_en_q);
        REG_PEND:    rdata_d = zext(pend_q);
        default:     rdata_d = '0;
      endcase
    end

    if (wr_en) begin
      case (reg_sel)
        REG_OE:      oe_d      = merge(oe_q, wdata, wmask);
        REG_DO:      do_d      = merge(do_q, wdata, wmask);
        REG_RISE_EN: rise_en_d = merge(rise_en_q, wdata, wmask);
        REG_FALL_EN: fall_en_d = merge(fall_en_q, wdata, wmask);
        REG_PEND:    pend_clr  = wbits;
        REG_DO_SET:  do_d      = do_q | wbits;
        REG_DO_CLR:  do_d      = do_q & ~wbits;
        default:     ;
      endcase
    end

    // A new edge event wins over a simultaneous write-1-to-clear.
    pend_d = (pend_q & ~pend_clr) | pend_set;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      oe_q      <= '0;
      do_q      <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      pend_q    <= '0;
      s1_q      <= '0;
      s2_q      <= '0;
      s3_q      <= '0;
      ready_q   <= 1'b0;
      rdata_q   <= '0;
      irq_q     <= 1'b0;
    end else begin
      oe_q      <= oe_d;
      do_q      <= do_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      pend_q    <= pend_d;
      s1_q      <= gpio_in_i;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      ready_q   <= accept;
      rdata_q   <= rdata_d;
      irq_q     <= |pend_d;
    end
  end

  assign mem_ready_o = ready_q;
  assign mem_rdata_o = rdata_q;
  assign gpio_out_o  = do_q;
  assign gpio_oe_o   = oe_q;
  assign irq_o       = irq_q;

endmodule

// File: tb/tb_user_gpio_ctrl.sv
// Directed bench for user_gpio_ctrl: register table plus edge, collision,
// back-to-back and reset sequences on a 16-line and a 5-line instance.
module tb_user_gpio_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic [7:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic [15:0] gpio_in = '0;

  logic        ready, ready5, irq, irq5;
  logic [31:0] rdata, rdata5;
  logic [15:0] gpio_out, gpio_oe;
  logic [4:0]  gpio_out5, gpio_oe5;

  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] rd, rd5;

  always #5 clk = ~clk;

  user_gpio_ctrl #(.GPIO_NUM(16)) u_dut (
    .clk_i(clk), .rst_i(rst), .mem_valid_i(valid), .mem_addr_i(addr),
    .mem_wdata_i(wdata), .mem_wstrb_i(wstrb), .mem_ready_o(ready),
    .mem_rdata_o(rdata), .gpio_out_o(gpio_out), .gpio_oe_o(gpio_oe),
    .gpio_in_i(gpio_in), .irq_o(irq)
  );

  user_gpio_ctrl #(.GPIO_NUM(5)) u_dut5 (
    .clk_i(clk), .rst_i(rst), .mem_valid_i(valid), .mem_addr_i(addr),
    .mem_wdata_i(wdata), .mem_wstrb_i(wstrb), .mem_ready_o(ready5),
    .mem_rdata_o(rdata5), .gpio_out_o(gpio_out5), .gpio_oe_o(gpio_oe5),
    .gpio_in_i(gpio_in[4:0]), .irq_o(irq5)
  );

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp_rd;
    logic [15:0] exp_oe;
    logic [15:0] exp_do;
    logic [4:0]  exp_oe5;
    logic [4:0]  exp_do5;
    logic [31:0] exp_rd5;
  } vec_t;

  vec_t vecs [21];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Call at a negedge with ready low; returns at a negedge with ready low again.
  task automatic bus_xfer(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [31:0] r, output logic [31:0] r5);
    valid = 1'b1; addr = a; wdata = d; wstrb = s;
    @(posedge clk); #1;
    check("ready_pulse", 32'(ready), 32'd1);
    check("ready_pulse5", 32'(ready5), 32'd1);
    r = rdata; r5 = rdata5;
    valid = 1'b0; wstrb = '0;
    @(posedge clk); #1;
    check("ready_single", 32'(ready), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs = '{
      '{8'h00, 32'h0000A5A5, 4'b0001, 32'h0,        16'h00A5, 16'h0000, 5'h05, 5'h00, 32'h0},
      '{8'h00, 32'h0,        4'b0000, 32'h000000A5, 16'h00A5, 16'h0000, 5'h05, 5'h00, 32'h05},
      '{8'h04, 32'h000000F0, 4'b1111, 32'h0,        16'h00A5, 16'h00F0, 5'h05, 5'h10, 32'h0},
      '{8'h18, 32'h0000000F, 4'b1111, 32'h0,        16'h00A5, 16'h00FF, 5'h05, 5'h1F, 32'h0},
      '{8'h1C, 32'h00000081, 4'b1111, 32'h0,        16'h00A5, 16'h007E, 5'h05, 5'h1E, 32'h0},
      '{8'h18, 32'h0,        4'b0000, 32'h0,        16'h00A5, 16'h007E, 5'h05, 5'h1E, 32'h0},
      '{8'h04, 32'h0,        4'b0000, 32'h0000007E, 16'h00A5, 16'h007E, 5'h05, 5'h1E, 32'h1E},
      '{8'h04, 32'hFFFF1234, 4'b0010, 32'h0,        16'h00A5, 16'h127E, 5'h05, 5'h1E, 32'h0},
      '{8'h04, 32'h0,        4'b0000, 32'h0000127E, 16'h00A5, 16'h127E, 5'h05, 5'h1E, 32'h1E},
      '{8'h08, 32'hFFFFFFFF, 4'b1111, 32'h0,        16'h00A5, 16'h127E, 5'h05, 5'h1E, 32'h0},
      '{8'h08, 32'h0,        4'b0000, 32'h0,        16'h00A5, 16'h127E, 5'h05, 5'h1E, 32'h0},
      '{8'h1C, 32'h000000FF, 4'b0001, 32'h0,        16'h00A5, 16'h1200, 5'h05, 5'h00, 32'h0},
      '{8'h1C, 32'h0,        4'b0000, 32'h0,        16'h00A5, 16'h1200, 5'h05, 5'h00, 32'h0},
      '{8'h18, 32'h0000FF00, 4'b0010, 32'h0,        16'h00A5, 16'hFF00, 5'h05, 5'h00, 32'h0},
      '{8'h0C, 32'h00000004, 4'b1111, 32'h0,        16'h00A5, 16'hFF00, 5'h05, 5'h00, 32'h0},
      '{8'h0C, 32'h0,        4'b0000, 32'h00000004, 16'h00A5, 16'hFF00, 5'h05, 5'h00, 32'h04},
      '{8'h10, 32'h0,        4'b1111, 32'h0,        16'h00A5, 16'hFF00, 5'h05, 5'h00, 32'h0},
      '{8'h10, 32'h0,        4'b0000, 32'h0,        16'h00A5, 16'hFF00, 5'h05, 5'h00, 32'h0},
      '{8'h00, 32'hFFFFFFFF, 4'b1111, 32'h0,        16'hFFFF, 16'hFF00, 5'h1F, 5'h00, 32'h0},
      '{8'h00, 32'h0,        4'b0000, 32'h0000FFFF, 16'hFFFF, 16'hFF00, 5'h1F, 5'h00, 32'h1F},
      '{8'h03, 32'h0,        4'b0000, 32'h0000FFFF, 16'hFFFF, 16'hFF00, 5'h1F, 5'h00, 32'h1F}
    };

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_out", 32'(gpio_out), 32'd0);
    check("rst_oe", 32'(gpio_oe), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_rdata", rdata, 32'd0);

    for (int i = 0; i < 21; i++) begin
      bus_xfer(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, rd, rd5);
      if (vecs[i].wstrb == 4'b0000) begin
        check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
        check($sformatf("vec%0d_rdata5", i), rd5, vecs[i].exp_rd5);
      end
      check($sformatf("vec%0d_oe", i), 32'(gpio_oe), 32'(vecs[i].exp_oe));
      check($sformatf("vec%0d_do", i), 32'(gpio_out), 32'(vecs[i].exp_do));
      check($sformatf("vec%0d_oe5", i), 32'(gpio_oe5), 32'(vecs[i].exp_oe5));
      check($sformatf("vec%0d_do5", i), 32'(gpio_out5), 32'(vecs[i].exp_do5));
    end

    // Valid held high: accepted every other cycle.
    valid = 1'b1; addr = 8'h00; wstrb = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check($sformatf("b2b_ready%0d", i), 32'(ready), ((i % 2) == 0) ? 32'd1 : 32'd0);
      if ((i % 2) == 0) check($sformatf("b2b_rdata%0d", i), rdata, 32'h0000FFFF);
    end
    valid = 1'b0;
    @(negedge clk);

    // Rising edge on bit 2 with RISE_EN=0x4.
    gpio_in = 16'h0004;
    @(posedge clk); #1;
    check("rise_k_irq", 32'(irq), 32'd0);
    @(posedge clk); #1;
    check("rise_k1_irq", 32'(irq), 32'd0);
    @(posedge clk); #1;
    check("rise_k2_irq", 32'(irq), 32'd1);
    check("rise_k2_irq5", 32'(irq5), 32'd1);
    @(negedge clk);
    bus_xfer(8'h14, 32'h0, 4'b0000, rd, rd5);
    check("rise_pend", rd, 32'h4);
    check("rise_pend5", rd5, 32'h4);
    bus_xfer(8'h08, 32'h0, 4'b0000, rd, rd5);
    check("di_read", rd, 32'h4);
    check("di_read5", rd5, 32'h4);

    bus_xfer(8'h14, 32'h00000004, 4'b0001, rd, rd5);
    check("w1c_irq", 32'(irq), 32'd0);
    check("w1c_irq5", 32'(irq5), 32'd0);
    gpio_in = 16'h0000;
    repeat (5) @(posedge clk);
    #1 check("fall_no_irq", 32'(irq), 32'd0);
    @(negedge clk);
    bus_xfer(8'h14, 32'h0, 4'b0000, rd, rd5);
    check("fall_pend", rd, 32'h0);

    // Clear lands on the same edge that sets PEND[2].
    gpio_in = 16'h0004;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    valid = 1'b1; addr = 8'h14; wdata = 32'h00000004; wstrb = 4'b1111;
    @(posedge clk); #1;
    check("coll_ready", 32'(ready), 32'd1);
    check("coll_irq", 32'(irq), 32'd1);
    valid = 1'b0; wstrb = '0;
    @(posedge clk);
    @(negedge clk);
    bus_xfer(8'h14, 32'h0, 4'b0000, rd, rd5);
    check("coll_pend", rd, 32'h4);
    check("coll_pend5", rd5, 32'h4);
    valid = 1'b1; addr = 8'h14; wdata = 32'h00000004; wstrb = 4'b1111;
    @(posedge clk); #1;
    check("clr_ready", 32'(ready), 32'd1);
    check("clr_irq_drop", 32'(irq), 32'd0);
    check("clr_irq_drop5", 32'(irq5), 32'd0);
    valid = 1'b0; wstrb = '0;
    @(posedge clk);
    @(negedge clk);

    // Reset arrives on the edge that would accept a DO write.
    gpio_in = 16'h0000;
    repeat (4) @(posedge clk);
    @(negedge clk);
    gpio_in = 16'h0004;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("pre_rst_irq", 32'(irq), 32'd1);
    rst = 1'b1; valid = 1'b1; addr = 8'h04; wdata = 32'hFFFFFFFF; wstrb = 4'b1111;
    @(posedge clk); #1;
    check("midrst_ready", 32'(ready), 32'd0);
    check("midrst_do", 32'(gpio_out), 32'd0);
    check("midrst_oe", 32'(gpio_oe), 32'd0);
    check("midrst_irq", 32'(irq), 32'd0);
    check("midrst_irq5", 32'(irq5), 32'd0);
    @(negedge clk);
    rst = 1'b0; valid = 1'b0; wstrb = '0;
    @(posedge clk); #1;
    check("postrst_ready", 32'(ready), 32'd0);
    check("postrst_do", 32'(gpio_out), 32'd0);
    repeat (5) @(posedge clk);
    #1 check("sync_fill_irq", 32'(irq), 32'd0);
    @(negedge clk);
    bus_xfer(8'h08, 32'h0, 4'b0000, rd, rd5);
    check("postrst_di", rd, 32'h4);
    bus_xfer(8'h14, 32'h0, 4'b0000, rd, rd5);
    check("postrst_pend", rd, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
